aes_inv_mix_columns_iter: RTL and testbench

- Iterative AES InvMixColumns over a full 128-bit state, for the decryption datapath.
- Processes PAR_COLS columns per clock through instances of a combinational single-column inverse core.
- Upstream and downstream use valid/ready handshakes, so the block sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the round pipeline.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_inv_mix_columns_iter_if.sv | 37 +++
 rtl/aes_inv_mix_single_column.sv | 28 ++
 rtl/aes_inv_mix_columns_iter.sv | 118 +++++++++++
 tb/tb_aes_inv_mix_columns_iter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared AES types, GF(2^8) helpers and InvMixColumns FSM encoding
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int C_NUM_COLS = 4;
  localparam logic [7:0] C_GF_POLY = 8'h1b;

  typedef logic [0:15][7:0] state_t;
  typedef logic [0:3][7:0]  column_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? C_GF_POLY : 8'h00);
  endfunction

  // Shift-and-add over xtime powers; constant multipliers fold to XOR trees.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pwr;
    acc = 8'h00;
    pwr = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ pwr;
      end
      pwr = xtime(pwr);
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_mix_columns_iter_if.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_columns_iter_if : upstream/downstream valid-ready state bus
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aes_inv_mix_columns_iter_if;
  import aes_pkg::*;

  logic   valid_i;
  logic   ready_o;
  state_t state_i;
  logic   valid_o;
  logic   ready_i;
  state_t state_o;

  modport slave (
    input  valid_i,
    input  state_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output state_o
  );

  modport master (
    output valid_i,
    output state_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  state_o
  );

endinterface

`default_nettype wire

// File: rtl/aes_inv_mix_single_column.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_single_column : combinational InvMixColumns on one 4-byte column
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_inv_mix_single_column
  import aes_pkg::*;
(
  input  column_t state_i,
  output column_t state_o
);

  // First row of the inverse matrix; row r is this row rotated right by r.
  localparam logic [7:0] C_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  always_comb begin
    state_o = '0;
    for (int r = 0; r < C_NUM_COLS; r++) begin
      for (int j = 0; j < C_NUM_COLS; j++) begin
        state_o[r] = state_o[r] ^ gf_mul(state_i[j], C_COEF[2'(j - r)]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_columns_iter : iterative InvMixColumns, PAR_COLS columns per clock
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int PAR_COLS = 1
)
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  aes_inv_mix_columns_iter_if.slave  bus
);

  if (PAR_COLS != 1 && PAR_COLS != 2 && PAR_COLS != 4) begin : g_bad_par_cols
    $error("aes_inv_mix_columns_iter: PAR_COLS must be 1, 2 or 4");
  end

  // With PAR_COLS=4 the step truncates to 0: one pass covers every column.
  localparam logic [1:0] C_CNT_STEP = 2'(PAR_COLS);
  localparam logic [1:0] C_LAST_OFS = 2'(PAR_COLS - 1);

  inv_mc_state_e r_state;
  inv_mc_state_e w_state_nxt;
  logic [1:0]    r_cnt;
  state_t        r_work;
  state_t        w_work_nxt;
  logic          w_accept;
  logic          w_last;

  logic [1:0]    w_col_idx [PAR_COLS];
  column_t       w_col_in  [PAR_COLS];
  column_t       w_col_out [PAR_COLS];

  always_comb begin
    for (int k = 0; k < PAR_COLS; k++) begin
      w_col_idx[k] = r_cnt + 2'(k);
      for (int j = 0; j < C_NUM_COLS; j++) begin
        w_col_in[k][j] = r_work[{w_col_idx[k], 2'(j)}];
      end
    end
  end

  for (genvar k = 0; k < PAR_COLS; k++) begin : g_col
    aes_inv_mix_single_column u_col (
      .state_i (w_col_in[k]),
      .state_o (w_col_out[k])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < PAR_COLS; k++) begin
      for (int j = 0; j < C_NUM_COLS; j++) begin
        w_work_nxt[{w_col_idx[k], 2'(j)}] = w_col_out[k][j];
      end
    end
  end

  assign w_last = ((r_cnt + C_LAST_OFS) == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_work <= '0;
      r_cnt  <= 2'd0;
    end else if (w_accept) begin
      r_work <= bus.state_i;
      r_cnt  <= 2'd0;
    end else if (r_state == BUSY) begin
      r_work <= w_work_nxt;
      r_cnt  <= r_cnt + C_CNT_STEP;
    end
  end

  assign bus.ready_o = (r_state == IDLE);
  assign bus.valid_o = (r_state == DONE);
  assign bus.state_o = r_work;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_mix_columns_iter : scoreboard bench over PAR_COLS = 1, 2, 4
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_inv_mix_columns_iter;
  import aes_pkg::*;

  localparam int N_DUT   = 3;
  localparam int TIMEOUT = 200;

  localparam state_t VEC_A = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam state_t EXP_A = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam state_t VEC_R = {4{32'hd5d5d7d6}};
  localparam state_t EXP_R = {4{32'hd4d4d4d5}};

  logic   clk_i = 1'b0;
  logic   rst_i = 1'b0;
  logic   r_vi [N_DUT];
  logic   r_ri [N_DUT];
  state_t r_si [N_DUT];
  logic   w_vo [N_DUT];
  logic   w_ro [N_DUT];
  state_t w_so [N_DUT];

  int sel        = 0;
  int ready_mode = 0;
  int cyc        = 0;
  int n_tests    = 0;
  int n_fail     = 0;
  logic prev_vo  = 1'b0;

  state_t sb_q  [$];
  int     acc_q [$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int PC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    aes_inv_mix_columns_iter_if u_if ();
    assign u_if.valid_i = r_vi[g];
    assign u_if.state_i = r_si[g];
    assign u_if.ready_i = r_ri[g];
    assign w_vo[g]      = u_if.valid_o;
    assign w_ro[g]      = u_if.ready_o;
    assign w_so[g]      = u_if.state_o;
    aes_inv_mix_columns_iter #(.PAR_COLS(PC)) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (u_if)
    );
  end

  function automatic int pc_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] b);
    return m2(b) ^ b;
  endfunction

  function automatic state_t fwd_mix(input state_t s);
    state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
      r[4*c]   = m2(a0) ^ m3(a1) ^ a2 ^ a3;
      r[4*c+1] = a0 ^ m2(a1) ^ m3(a2) ^ a3;
      r[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m3(a3);
      r[4*c+3] = m3(a0) ^ a1 ^ a2 ^ m2(a3);
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    s = {$urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic send(input state_t st, input state_t exp);
    int waited;
    waited = 0;
    @(negedge clk_i);
    r_vi[sel] = 1'b1;
    r_si[sel] = st;
    while (!w_ro[sel] && waited < TIMEOUT) begin
      @(negedge clk_i);
      waited++;
    end
    check("accept_ready", 128'(w_ro[sel]), 128'd1);
    if (w_ro[sel]) begin
      sb_q.push_back(exp);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk_i);
    #1;
    r_vi[sel] = 1'b0;
    r_si[sel] = rand_state();
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb_q.size() != 0 && waited < TIMEOUT) begin
      @(negedge clk_i);
      waited++;
    end
    check("drain_empty", 128'(sb_q.size()), 128'd0);
    @(negedge clk_i);
  endtask

  initial forever begin
    @(posedge clk_i);
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      if (d != sel || ready_mode == 0) r_ri[d] = 1'b1;
      else if (ready_mode == 1)        r_ri[d] = ($urandom_range(0, 3) != 0);
      else                             r_ri[d] = 1'b0;
    end
  end

  // Output side of the scoreboard: latency on each valid rise, data on handshake.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      prev_vo = 1'b0;
    end else begin
      if (w_vo[sel] && !prev_vo) begin
        check("pending_txn", 128'(acc_q.size() > 0), 128'd1);
        if (acc_q.size() > 0) begin
          check("latency", 128'(cyc - acc_q[0]), 128'(4 / pc_of(sel)));
        end
      end
      if (w_vo[sel] && r_ri[sel]) begin
        check("out_expected", 128'(sb_q.size() > 0), 128'd1);
        if (sb_q.size() > 0) begin
          check("state_o", w_so[sel], sb_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_vo = w_vo[sel];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d entries still queued", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    state_t snap;
    state_t s;
    int     waited;
    int     n_rt;

    for (int d = 0; d < N_DUT; d++) begin
      r_vi[d] = 1'b0;
      r_ri[d] = 1'b1;
      r_si[d] = '0;
    end
    #1 rst_i = 1'b1;
    #2;
    for (int d = 0; d < N_DUT; d++) begin
      check("reset_valid_o", 128'(w_vo[d]), 128'd0);
      check("reset_ready_o", 128'(w_ro[d]), 128'd1);
      check("reset_state_o", w_so[d], '0);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    sel = 0;
    send(VEC_A, EXP_A);
    drain();

    for (int d = 0; d < N_DUT; d++) begin
      sel = d;
      send(VEC_R, EXP_R);
      drain();
    end

    // Backpressure while valid_i/state_i keep toggling through BUSY and DONE.
    sel = 0;
    ready_mode = 2;
    send(VEC_A, EXP_A);
    waited = 0;
    while (!w_vo[0] && waited < TIMEOUT) begin
      r_vi[0] = 1'b1;
      r_si[0] = rand_state();
      @(negedge clk_i);
      waited++;
    end
    check("bp_valid_rise", 128'(w_vo[0]), 128'd1);
    snap = w_so[0];
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", 128'(w_vo[0]), 128'd1);
      check("bp_ready_low", 128'(w_ro[0]), 128'd0);
      check("bp_state_hold", w_so[0], snap);
      r_vi[0] = 1'b1;
      r_si[0] = rand_state();
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    r_vi[0] = 1'b0;
    ready_mode = 0;
    r_ri[0] = 1'b1;
    @(posedge clk_i);
    #1;
    check("release_ready_o", 128'(w_ro[0]), 128'd1);
    check("release_valid_o", 128'(w_vo[0]), 128'd0);
    drain();

    // Asynchronous reset while the counter sits at 2.
    send(VEC_A, EXP_A);
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_valid_o", 128'(w_vo[0]), 128'd0);
    check("midrst_ready_o", 128'(w_ro[0]), 128'd1);
    check("midrst_state_o", w_so[0], '0);
    sb_q.delete();
    acc_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    send(VEC_A, EXP_A);
    drain();

    ready_mode = 1;
    for (int d = 0; d < N_DUT; d++) begin
      sel  = d;
      n_rt = (d == 0) ? 1000 : 200;
      for (int i = 0; i < n_rt; i++) begin
        s = rand_state();
        send(fwd_mix(s), s);
      end
      drain();
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
